reshaper_mem_rsp: RTL

Fixed-latency memory responder serving the reshaper's read and write ports. It accepts read requests on `raddr`/`raddr_vld` and returns `rdata`/`rdata_vld` exactly `MEM_DELAY` cycles later. It commits writes from `waddr`/`wdata`/`wdata_vld` into an internal word array. It sits opposite the reshaper in block-level benches and in FPGA bring-up builds, where it stands in for the scratchpad SRAM.

---
 rtl/reshaper_mem_pkg.sv | 15 +
 rtl/reshaper_mem_dly.sv | 69 ++++++
 rtl/reshaper_mem_rsp.sv | 129 ++++++++++++
 3 files changed

// File: rtl/reshaper_mem_pkg.sv
// rtl/reshaper_mem_pkg.sv - shared constants and delay-line stage type for reshaper_mem_rsp
package reshaper_mem_pkg;

   localparam int unsigned MEM_DELAY_MIN = 1;
   localparam int unsigned MEM_DELAY_MAX = 32;

   // Stage payload is sized for the widest supported data word.
   localparam int unsigned RSP_DW = 512;

   typedef struct packed {
      logic              vld;
      logic [RSP_DW-1:0] data;
   } rsp_stage_t;

endpackage

// File: rtl/reshaper_mem_dly.sv
// rtl/reshaper_mem_dly.sv - valid+data shift register of depth N, async reset, sync clear of valids
module reshaper_mem_dly
   import reshaper_mem_pkg::*;
#(
   parameter int unsigned N = 7
) (
   input  logic       clk_i,
   input  logic       reset_n_i,
   input  logic       clr_i,
   input  rsp_stage_t in_i,
   output rsp_stage_t out_o
);

   if (N == 0) begin : g_pass
      assign out_o = in_i;
   end else begin : g_pipe
      logic [N-1:0]      vld_q;
      logic              last_en;
      logic [RSP_DW-1:0] last_in;
      logic [RSP_DW-1:0] last_q;

      always_ff @(posedge clk_i or negedge reset_n_i) begin
         if (!reset_n_i) begin
            vld_q <= '0;
         end else if (clr_i) begin
            vld_q <= '0;
         end else begin
            vld_q[0] <= in_i.vld;
            for (int i = 1; i < N; i++) begin
               vld_q[i] <= vld_q[i-1];
            end
         end
      end

      // Data stages load only behind a valid, so the output holds between responses.
      if (N == 1) begin : g_one
         assign last_en = in_i.vld;
         assign last_in = in_i.data;
      end else begin : g_mid
         logic [RSP_DW-1:0] mid_q [N-1];

         always_ff @(posedge clk_i) begin
            if (in_i.vld) begin
               mid_q[0] <= in_i.data;
            end
            for (int i = 1; i < N - 1; i++) begin
               if (vld_q[i-1]) begin
                  mid_q[i] <= mid_q[i-1];
               end
            end
         end

         assign last_en = vld_q[N-2];
         assign last_in = mid_q[N-2];
      end

      // Output stage data is reset so rdata starts at zero.
      always_ff @(posedge clk_i or negedge reset_n_i) begin
         if (!reset_n_i) begin
            last_q <= '0;
         end else if (last_en && !clr_i) begin
            last_q <= last_in;
         end
      end

      assign out_o = {vld_q[N-1], last_q};
   end

endmodule

// File: rtl/reshaper_mem_rsp.sv
// rtl/reshaper_mem_rsp.sv - fixed-latency memory responder for the reshaper read/write ports
// Optional write-first bypass on same-cycle same-index access: RESHAPER_MEM_FWD_EN.
module reshaper_mem_rsp
   import reshaper_mem_pkg::*;
#(
   parameter int unsigned AW        = 16,
   parameter int unsigned DW        = 512,
   parameter int unsigned DEPTH     = 1024,
   parameter int unsigned MEM_DELAY = 8
) (
   input  logic          clk_i,
   input  logic          reset_n_i,
   input  logic          init_pulse_i,
   input  logic [AW-1:0] raddr_i,
   input  logic          raddr_vld_i,
   output logic [DW-1:0] rdata_o,
   output logic          rdata_vld_o,
   input  logic [AW-1:0] waddr_i,
   input  logic [DW-1:0] wdata_i,
   input  logic          wdata_vld_i,
   output logic [AW-1:0] rd_cnt_o,
   output logic [AW-1:0] wr_cnt_o,
   output logic          oor_err_o
);

   localparam int unsigned IW = $clog2(DEPTH);

   if (MEM_DELAY < MEM_DELAY_MIN || MEM_DELAY > MEM_DELAY_MAX || DW > RSP_DW) begin : g_bad_cfg
      $error("reshaper_mem_rsp: MEM_DELAY or DW out of range");
   end

   logic [DW-1:0] mem_q [DEPTH];
   logic [IW-1:0] ridx;
   logic [IW-1:0] widx;
   logic          r_oor;
   logic          w_oor;
   logic [DW-1:0] arr_word;
   logic [DW-1:0] rd_word;
   rsp_stage_t    s1_q;
   rsp_stage_t    dly_out;
   logic [AW-1:0] rd_cnt_q, rd_cnt_d;
   logic [AW-1:0] wr_cnt_q, wr_cnt_d;
   logic          oor_q, oor_d;

   assign ridx = raddr_i[IW-1:0];
   assign widx = waddr_i[IW-1:0];

   if (IW < AW) begin : g_oor
      assign r_oor = |raddr_i[AW-1:IW];
      assign w_oor = |waddr_i[AW-1:IW];
   end else begin : g_no_oor
      assign r_oor = 1'b0;
      assign w_oor = 1'b0;
   end

   // Array is deliberately not reset; contents survive reset and init_pulse.
   always_ff @(posedge clk_i) begin
      if (wdata_vld_i && !w_oor) begin
         mem_q[widx] <= wdata_i;
      end
   end

`ifdef RESHAPER_MEM_FWD_EN
   logic fwd_hit;
   assign fwd_hit  = wdata_vld_i && !w_oor && (widx == ridx);
   assign arr_word = fwd_hit ? wdata_i : mem_q[ridx];
`else
   assign arr_word = mem_q[ridx];
`endif

   assign rd_word = r_oor ? '0 : arr_word;

   // Stage 1 always takes the current request, even during init_pulse.
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         s1_q <= '0;
      end else begin
         s1_q.vld <= raddr_vld_i;
         if (raddr_vld_i) begin
            s1_q.data <= RSP_DW'(rd_word);
         end
      end
   end

   reshaper_mem_dly #(
      .N (MEM_DELAY - 1)
   ) u_dly (
      .clk_i     (clk_i),
      .reset_n_i (reset_n_i),
      .clr_i     (init_pulse_i),
      .in_i      (s1_q),
      .out_o     (dly_out)
   );

   assign rdata_o     = dly_out.data[DW-1:0];
   assign rdata_vld_o = dly_out.vld;

   always_comb begin
      rd_cnt_d = init_pulse_i ? '0 : rd_cnt_q;
      wr_cnt_d = init_pulse_i ? '0 : wr_cnt_q;
      oor_d    = init_pulse_i ? 1'b0 : oor_q;
      if (raddr_vld_i) begin
         rd_cnt_d = rd_cnt_d + AW'(1);
      end
      if (wdata_vld_i) begin
         wr_cnt_d = wr_cnt_d + AW'(1);
      end
      if ((raddr_vld_i && r_oor) || (wdata_vld_i && w_oor)) begin
         oor_d = 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         rd_cnt_q <= '0;
         wr_cnt_q <= '0;
         oor_q    <= 1'b0;
      end else begin
         rd_cnt_q <= rd_cnt_d;
         wr_cnt_q <= wr_cnt_d;
         oor_q    <= oor_d;
      end
   end

   assign rd_cnt_o  = rd_cnt_q;
   assign wr_cnt_o  = wr_cnt_q;
   assign oor_err_o = oor_q;

endmodule
